voice_mixer: RTL
================

Name: voice_mixer

Overview:
Downstream of the per-voice dynamics stage. It collects one attenuated sample from each active voice per codec frame, sums them as signed values, and applies a master attenuation shift. The result is saturated to 16 bits and presented to the codec interface with a one-cycle ready pulse. It also reports voices that fail to deliver in time, and frame requests that arrive while a frame is still being mixed.

Parameters:
NUM_VOICES, 3, number of voice inputs; legal range 1..4
SAMPLE_W, 16, sample width in bits, signed two's complement
TIMEOUT, 64, cycles allowed in COLLECT before missing voices are forced to 0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
generate_next_sample  in  1  one-cycle frame request from the codec; starts a mix frame
voice_enable  in  NUM_VOICES  per-voice enable; a disabled voice contributes 0 and is never waited on
voice_sample  in  NUM_VOICES*SAMPLE_W  packed voice samples; voice i at [SAMPLE_W*i+SAMPLE_W-1 : SAMPLE_W*i]
voice_valid  in  NUM_VOICES  per-voice one-cycle strobe; voice_sample[i] is valid while voice_valid[i] is high
master_shift  in  2  arithmetic right shift applied to the sum (0..3); sampled in SUM
mix_sample  out  SAMPLE_W  mixed, saturated sample; held until the next mix_ready
mix_ready  out  1  one-cycle pulse when mix_sample updates
underrun  out  1  one-cycle pulse coincident with mix_ready when at least one enabled voice timed out
overrun  out  1  one-cycle pulse when generate_next_sample arrives outside IDLE

Behaviour:
- Reset: state IDLE; mix_sample=0; mix_ready=0; underrun=0; overrun=0; capture flags, capture registers and timeout counter cleared. Reset in any state aborts the frame with no mix_ready.
- IDLE:
  - voice_valid is ignored.
  - On generate_next_sample: clear capture registers to 0 and the got[] flags; set got[i]=1 for each disabled voice; clear the timeout counter; go to COLLECT.
  - voice_enable is sampled on this cycle and held for the whole frame.
- COLLECT:
  - Per cycle, for each i with got[i]=0 and voice_valid[i]=1: capture voice_sample[i] and set got[i].
  - The first capture wins; repeat strobes from a voice already captured are ignored.
  - Timeout counter increments every cycle.
  - Go to SUM when all got[] are set. This includes the cycle in which the final capture occurs, which is registered first.
  - Also go to SUM when the counter reaches TIMEOUT-1. In that case set the internal timed_out flag if any got[i]=0; uncaptured voices stay 0.
  - If no voices are enabled, go to SUM on the first COLLECT cycle.
- SUM (one cycle):
  - sum = signed sum of captures at width SAMPLE_W+2, then arithmetic right shift by master_shift.
  - Saturate to [-32768, +32767].
  - Register the result into mix_sample; pulse mix_ready; pulse underrun if timed_out; go to IDLE.
- Latency: the cycle after the final capture is SUM; mix_ready is high the following cycle, i.e. 2 cycles after the last voice_valid.
- overrun:
  - Pulses for one cycle when generate_next_sample is high in COLLECT or SUM.
  - The request is dropped; the current frame continues unaffected.
- Simultaneous events: generate_next_sample together with voice_valid in IDLE → start the frame; that valid is not captured.
- mix_sample changes only on the mix_ready cycle.

Decomposition:
- Shared package:
  - SAMPLE_W
  - SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000
  - state encoding IDLE/COLLECT/SUM (2-bit)
  - TIMEOUT default
- Sub-module sample_saturate: a combinational signed clamp from SAMPLE_W+2 bits to SAMPLE_W bits, reusable by later effect stages. Everything else (FSM, capture registers, counter) stays in voice_mixer.

Test Plan:
1. All 3 voices enabled, master_shift=0. Request, then valids on cycles +1, +3, +2 with 1000, -200, 300 → mix_sample=1100; mix_ready exactly 2 cycles after the last valid; underrun=0.
2. Saturation, master_shift=0:
   - Voices 20000, 20000, 5000 → mix_sample=32767.
   - Voices -20000, -20000, -5000 → -32768.
   - Repeat the positive case with master_shift=2 → 11250.
3. Voice 1 enabled but never valid, TIMEOUT=64; voices 0 and 2 send 500 and 700 → mix_sample=1200; underrun pulses with mix_ready at cycle 64+2 after the request.
4. voice_enable=3'b000, request → mix_ready with mix_sample=0 within 3 cycles, no underrun.
5. Second generate_next_sample during COLLECT → overrun pulses one cycle; only one mix_ready for the frame. A repeat valid from voice 0 carrying 9999 after its first capture of 10 → the sum uses 10.
6. Reset asserted in COLLECT after two captures → no mix_ready; mix_sample=0. The next request yields a clean frame with no stale captures.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// Shared definitions for the voice mixer and later effect stages:
// sample width, saturation limits, mixer state encoding and default timeout.
package voice_mixer_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int SUM_W           = SAMPLE_W + 2;
    localparam int TIMEOUT_DEFAULT = 64;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUM     = 2'd2
    } mix_state_e;

endpackage

// File: rtl/voice_mixer_sample_saturate.sv
// Combinational signed clamp from the widened accumulator width down to one
// sample; shared by the mixer and any later effect stage.
module voice_mixer_sample_saturate
    import voice_mixer_pkg::*;
(
    input  logic signed [SUM_W-1:0]    din,
    output logic signed [SAMPLE_W-1:0] dout
);

    localparam logic signed [SUM_W-1:0] MAX_EXT = SUM_W'(SAT_MAX);
    localparam logic signed [SUM_W-1:0] MIN_EXT = SUM_W'(SAT_MIN);

    // Clamp to the representable sample range
    always_comb begin
        dout = din[SAMPLE_W-1:0];
        if (din > MAX_EXT) begin
            dout = SAT_MAX;
        end else if (din < MIN_EXT) begin
            dout = SAT_MIN;
        end else begin
            dout = din[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// Per-frame voice mixer: gathers one sample per enabled voice, sums, shifts,
// saturates and hands the result to the codec with a one-cycle ready pulse.
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           generate_next_sample,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_valid,
    input  logic [1:0]                     master_shift,
    output logic [SAMPLE_W-1:0]            mix_sample,
    output logic                           mix_ready,
    output logic                           underrun,
    output logic                           overrun
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    mix_state_e                  state_r, state_next_s;
    logic [NUM_VOICES-1:0]       got_r, got_upd_s;
    logic signed [SAMPLE_W-1:0]  cap_r [NUM_VOICES];
    logic [CNT_W-1:0]            cnt_r;
    logic                        timed_out_r;
    logic                        all_got_s, timeout_hit_s;
    logic signed [SUM_W-1:0]     sum_s, shifted_s;
    logic signed [SAMPLE_W-1:0]  sat_s;
    logic signed [SAMPLE_W-1:0]  mix_sample_r, mix_next_s;
    logic                        ready_r, ready_next_s;
    logic                        underrun_r, underrun_next_s;
    logic                        overrun_r, overrun_next_s;

    // Capture-progress view including strobes arriving this cycle
    always_comb begin
        got_upd_s     = got_r | voice_valid;
        all_got_s     = &got_upd_s;
        timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (generate_next_sample) state_next_s = COLLECT;
                else                      state_next_s = IDLE;
            end
            COLLECT: begin
                if (all_got_s || timeout_hit_s) state_next_s = SUM;
                else                            state_next_s = COLLECT;
            end
            SUM:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Capture registers, got flags, timeout counter; disabled voices pre-marked as got
    always_ff @(posedge clk) begin
        if (reset) begin
            got_r       <= '0;
            cnt_r       <= '0;
            timed_out_r <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) cap_r[i] <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (generate_next_sample) begin
                        got_r       <= ~voice_enable;
                        cnt_r       <= '0;
                        timed_out_r <= 1'b0;
                        for (int i = 0; i < NUM_VOICES; i++) cap_r[i] <= '0;
                    end
                end
                COLLECT: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (!got_r[i] && voice_valid[i]) begin
                            cap_r[i] <= voice_sample[SAMPLE_W*i +: SAMPLE_W];
                        end
                    end
                    got_r <= got_upd_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (timeout_hit_s && !all_got_s) timed_out_r <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Widened signed sum of captures followed by the master attenuation
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum_s = sum_s + SUM_W'(cap_r[i]);
        end
        shifted_s = sum_s >>> master_shift;
    end

    voice_mixer_sample_saturate u_sat (
        .din  (shifted_s),
        .dout (sat_s)
    );

    // Output decode: result and pulses are produced only from SUM
    always_comb begin
        ready_next_s    = 1'b0;
        underrun_next_s = 1'b0;
        mix_next_s      = mix_sample_r;
        overrun_next_s  = generate_next_sample && (state_r != IDLE);
        if (state_r == SUM) begin
            ready_next_s    = 1'b1;
            underrun_next_s = timed_out_r;
            mix_next_s      = sat_s;
        end else begin
            ready_next_s    = 1'b0;
            underrun_next_s = 1'b0;
            mix_next_s      = mix_sample_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            mix_sample_r <= '0;
            ready_r      <= 1'b0;
            underrun_r   <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            mix_sample_r <= mix_next_s;
            ready_r      <= ready_next_s;
            underrun_r   <= underrun_next_s;
            overrun_r    <= overrun_next_s;
        end
    end

    assign mix_sample = mix_sample_r;
    assign mix_ready  = ready_r;
    assign underrun   = underrun_r;
    assign overrun    = overrun_r;

endmodule
